// File: rtl/memory_game_pkg.sv
// Shared definitions for the memory game blocks: symbol/pattern sizing,
// the pattern player state encoding and the symbol-to-LED decode.
package memory_game_pkg;

  localparam int SYM_W   = 3;                    // bits per symbol (LED index 0-7)
  localparam int MAX_LEN = 25;                   // symbols a pattern can hold
  localparam int LEN_W   = $clog2(MAX_LEN + 1);  // width of a length value 0..MAX_LEN
  localparam int SLOT_W  = $clog2(MAX_LEN);      // width of a slot index 0..MAX_LEN-1

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } player_state_t;

  // One-hot LED drive for a symbol; every symbol value maps to exactly one LED.
  function automatic logic [7:0] sym_to_led(input logic [SYM_W-1:0] sym);
    logic [7:0] l;
    l      = 8'h00;
    l[sym] = 1'b1;
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter. A load strobe sets the count; otherwise it counts
// down one per cycle and parks at zero. expired_o is high while the count
// is zero, so a load of N-1 gives a phase of exactly N cycles.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: reload on strobe, else count down without wrapping below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/pattern_player.sv
// Pattern player: plays a latched symbol pattern on the 8 LEDs, ON_CYCLES lit
// per symbol with OFF_CYCLES blank between symbols, then pulses done.
// Forward order is oldest-first (slot L-1 down to 0), reverse is newest-first.
// Optional tone output is built only when PATTERN_PLAYER_TONE_EN is defined;
// otherwise tone is tied low and no divider exists.
module pattern_player
  import memory_game_pkg::*;
#(
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000,
  parameter int TONE_BASE  = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [MAX_LEN*SYM_W-1:0] pattern,
  input  logic [LEN_W-1:0]         len,
  input  logic                     reverse,
  input  logic                     abort,
  output logic [7:0]               led,
  output logic                     busy,
  output logic                     done,
  output logic [SLOT_W-1:0]        sym_idx,
  output logic                     tone
);

  localparam int MAX_PHASE = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W     = $clog2(MAX_PHASE + 1);

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

  player_state_t            state_q, state_d;
  logic [MAX_LEN*SYM_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic                     rev_q, rev_d;
  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic [SYM_W-1:0]         sym_d;
  logic [7:0]               led_q;
  logic                     busy_q, done_q;

  logic                     tmr_load;
  logic [CNT_W-1:0]         tmr_val;
  logic                     tmr_exp;

  logic [LEN_W-1:0]         len_clamp, len_clamp_m1, len_q_m1;
  logic                     last_sym;

  // Over-long requests play the full buffer rather than wrapping.
  assign len_clamp    = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign len_clamp_m1 = len_clamp - 1'b1;
  assign len_q_m1     = len_q - 1'b1;

  // The symbol being shown is the final one in the chosen play order.
  assign last_sym = rev_q ? (slot_q == SLOT_W'(len_q_m1)) : (slot_q == '0);

  phase_timer #(
    .W (CNT_W)
  ) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );

  // Next-state, latch and timer-load decisions; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    rev_d    = rev_q;
    slot_d   = slot_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pat_d = pattern;
            len_d = len_clamp;
            rev_d = reverse;
            if (len_clamp == '0) begin
              state_d = DONE;
            end else begin
              state_d  = ON;
              slot_d   = reverse ? '0 : SLOT_W'(len_clamp_m1);
              tmr_load = 1'b1;
              tmr_val  = ON_LOAD;
            end
          end
        end
        ON: begin
          if (tmr_exp) begin
            if (last_sym) begin
              state_d = DONE;
            end else begin
              state_d  = GAP;
              tmr_load = 1'b1;
              tmr_val  = OFF_LOAD;
            end
          end
        end
        GAP: begin
          if (tmr_exp) begin
            state_d  = ON;
            slot_d   = rev_q ? slot_q + 1'b1 : slot_q - 1'b1;
            tmr_load = 1'b1;
            tmr_val  = ON_LOAD;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Symbol for the slot that will be shown next cycle.
    sym_d = pat_d[slot_d*SYM_W +: SYM_W];
  end

  // State, latched request and registered outputs derived from next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rev_q   <= 1'b0;
      slot_q  <= '0;
      led_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rev_q   <= rev_d;
      slot_q  <= slot_d;
      led_q   <= (state_d == ON) ? sym_to_led(sym_d) : 8'h00;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign led     = led_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sym_idx = slot_q;

`ifdef PATTERN_PLAYER_TONE_EN
  localparam int TONE_W = $clog2(TONE_BASE * (2 ** SYM_W) + 1);

  logic [TONE_W-1:0] tone_cnt_q;
  logic [TONE_W-1:0] tone_half_m1;
  logic              tone_q;

  // Half-period grows with the symbol value so each LED has its own pitch.
  assign tone_half_m1 = TONE_W'(TONE_BASE * (int'(sym_d) + 1) - 1);

  // Square wave during ON only; restarts low on each ON entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tone_q     <= 1'b0;
      tone_cnt_q <= '0;
    end else if (state_d != ON) begin
      tone_q     <= 1'b0;
      tone_cnt_q <= '0;
    end else if (state_q != ON) begin
      tone_q     <= 1'b0;
      tone_cnt_q <= tone_half_m1;
    end else if (tone_cnt_q == '0) begin
      tone_q     <= ~tone_q;
      tone_cnt_q <= tone_half_m1;
    end else begin
      tone_cnt_q <= tone_cnt_q - 1'b1;
    end
  end

  assign tone = tone_q;
`else
  // No divider in this build; TONE_BASE only keeps the parameter list uniform.
  assign tone = 1'b0 & (TONE_BASE == 0);
`endif

endmodule

// File: doc/pattern_player.md
Name: pattern_player

Overview:
- Transmitter counterpart to the user-input collector. Plays a stored game pattern out to the 8 LEDs one symbol at a time, with a timed ON phase and a timed blank gap between symbols.
- Instantiated beside the mode FSMs. The FSM pulses start after PATTERN_GEN and waits for done before enabling input capture.
- Supports forward (oldest-first) and reverse (newest-first) playback for reverse mode.

Parameters:
- MAX_LEN, 25, maximum symbols held in pattern.
- SYM_W, 3, bits per symbol (LED index 0-7).
- ON_CYCLES, 25000000, clk cycles each symbol is lit (>=1).
- OFF_CYCLES, 12500000, clk cycles of blank gap between symbols (>=1).
- TONE_BASE, 1000, half-period unit for the optional tone output.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle request to begin playback; honoured only in IDLE.
- pattern  in  MAX_LEN*SYM_W  symbols packed newest-at-LSB: slot s = pattern[s*SYM_W +: SYM_W]; slot 0 is newest.
- len  in  $clog2(MAX_LEN+1)  number of valid symbols.
- reverse  in  1  1 = newest-first playback.
- abort  in  1  cancel playback immediately.
- led  out  8  one-hot LED drive.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  single-cycle pulse at completion.
- sym_idx  out  $clog2(MAX_LEN)  slot currently being shown (debug).
- tone  out  1  square wave; constant 0 when the optional feature is disabled.

Behaviour:
- Reset: state IDLE; led=0, busy=0, done=0, sym_idx=0, tone=0; all counters cleared.
- States:
  - IDLE: wait for start.
  - ON: led = one-hot of current symbol.
  - GAP: led=0.
  - DONE: one cycle, done=1, led=0.
- Start acceptance (IDLE with start=1): latch pattern, len and reverse.
  - Latched len is clamped to MAX_LEN.
  - Later changes on the inputs are ignored until the next accepted start.
- Slot order for latched length L:
  - Forward: slots L-1, L-2, ..., 0.
  - Reverse: slots 0, 1, ..., L-1.
- Timing, start accepted at cycle T:
  - ON begins at T+1 and lasts exactly ON_CYCLES cycles.
  - If more symbols remain, GAP follows for exactly OFF_CYCLES cycles, then ON for the next symbol.
  - After the last ON phase, DONE occupies one cycle, then IDLE.
  - done is asserted at cycle T+1+L*ON_CYCLES+(L-1)*OFF_CYCLES.
- L=0: go directly to DONE at T+1. No LED is lit.
- start while not IDLE: ignored, no queuing.
- abort: takes priority over all transitions.
  - Next cycle: IDLE with led=0, busy=0; done is not pulsed.
  - abort together with start in IDLE: start is dropped.
- Back-to-back: start asserted in the first IDLE cycle after DONE is accepted.
- Reset mid-playback: returns to reset state on the next edge; no done pulse.
- led is registered and exactly one-hot during ON, all zero otherwise. It is never X for any 3-bit symbol.
- Phase counter width is $clog2(max(ON_CYCLES,OFF_CYCLES)+1). It loads at each phase entry and counts down to expiry with no wrap.

Optional Feature:
- Macro: PATTERN_PLAYER_TONE_EN.
- Defined:
  - During ON, tone toggles every TONE_BASE*(sym+1) cycles, giving a distinct pitch per symbol.
  - tone starts at 0 on each ON entry and is forced to 0 in IDLE, GAP and DONE.
- Undefined: tone tied to 0 and no divider logic is synthesised. Port list is unchanged.

Decomposition:
- Shared package memory_game_pkg holds:
  - SYM_W, MAX_LEN and the derived LEN_W.
  - The player_state_t enum {IDLE, ON, GAP, DONE}.
  - A one-hot decode function sym_to_led.
- One sub-module, phase_timer: loadable down-counter with load value, load strobe and expired flag. It is reused by the mode FSMs' timeout logic.
- The tone divider stays inline under the macro.

Test Plan (ON_CYCLES=4, OFF_CYCLES=2, TONE_BASE=2):
- Forward L=3, pattern slots {2:5, 1:0, 0:7}, start at T:
  - led=8'h20 for T+1..T+4, 0 for T+5..T+6.
  - led=8'h01 for T+7..T+10, 0 for T+11..T+12.
  - led=8'h80 for T+13..T+16.
  - done=1 at T+17 only; busy low at T+18.
- Same pattern with reverse=1: LED order 8'h80, 8'h01, 8'h20 with identical timing; done at T+17.
- L=0 start at T: led stays 0; done=1 at T+1; busy=1 only at T+1.
- Abort: assert abort at T+6 during L=3 playback. From T+7, led=0, busy=0, and done is never asserted. A new start at T+8 replays from the first symbol.
- Ignored start and clamp:
  - start pulsed at T+3 mid-playback: no effect on sequence or timing.
  - len=31: plays exactly 25 symbols; done at T+1+25*4+24*2 = T+149.
- With PATTERN_PLAYER_TONE_EN defined: symbol 1 gives tone period 8 cycles during ON and tone=0 during GAP. Without the macro, tone=0 throughout.
